spi_reg_write_ctrl: RTL and testbench

SPI controller (initiator) that drives 16-bit register-write frames into the chip's SPI peripheral. Used as the bench-side and on-chip counterpart of the peripheral, e.g. to program the PWM/output-enable register bank from a local sequencer.
- Mode 0: SCLK idles low; COPI changes on SCLK falling edge; the peripheral samples on the rising edge. MSB first.
- Frame layout: bit15 = R/W (1 = write), bits14:8 = address[6:0], bits7:0 = data[7:0].

---
 rtl/spi_ctrl_pkg.sv | 27 ++
 rtl/spi_clk_tick.sv | 29 ++
 rtl/spi_reg_write_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_reg_write_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and frame constants for the SPI register-write controller.
// Frame layout: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
package spi_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic WRITE_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: free-running CLK_DIV down-counter that pulses
// tick for one cycle at each phase boundary; clear holds it at the reload value.
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W  = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clear || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/spi_reg_write_ctrl.sv
// Mode-0 SPI initiator that sends one 16-bit register frame per request.
// Optional read support (rw_i, cipo_i, rdata_o) is enabled by SPI_CTRL_READ_EN.
module spi_reg_write_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef SPI_CTRL_READ_EN
  input  logic              rw_i,
  input  logic              cipo_i,
  output logic [DATA_W-1:0] rdata_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              sclk_o,
  output logic              copi_o,
  output logic              ncs_o
);

  import spi_ctrl_pkg::*;

  generate
    if (CLK_DIV < 2 || CLK_DIV > 255 ||
        ADDR_W != spi_ctrl_pkg::ADDR_W || DATA_W != spi_ctrl_pkg::DATA_W) begin : g_param_check
      $error("spi_reg_write_ctrl: CLK_DIV must be 2..255 and ADDR_W/DATA_W must be 7/8");
    end
  endgenerate

  state_t               state;
  state_t               state_next;
  logic [FRAME_W-1:0]   shift_q;
  logic [3:0]           bit_cnt;
  logic                 bits_done;
  logic                 sclk_q;
  logic                 done_q;
  logic                 tick;
  logic                 tick_clear;
  logic [FRAME_W-1:0]   frame_in;

`ifdef SPI_CTRL_READ_EN
  logic                 is_read_q;
  logic [DATA_W-1:0]    rx_q;
  logic [DATA_W-1:0]    rdata_q;

  assign frame_in = build_frame(rw_i, addr_i, data_i);
  assign rdata_o  = rdata_q;
`else
  assign frame_in = build_frame(WRITE_BIT, addr_i, data_i);
`endif

  // The divider idles in reload while IDLE so every frame starts with a full SETUP phase.
  assign tick_clear = (state == IDLE);

  spi_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = SETUP;
      SETUP:   if (tick) state_next = SHIFT;
      SHIFT:   if (tick && !sclk_q && bits_done) state_next = HOLD;
      HOLD:    if (tick) state_next = GAP;
      GAP:     if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    ncs_o  = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  end

  // Shifting in zeros means copi_o naturally returns low after the 16th falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt   <= 4'd0;
      bits_done <= 1'b0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          sclk_q <= 1'b0;
          if (start_i) begin
            shift_q   <= frame_in;
            bit_cnt   <= 4'd15;
            bits_done <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) sclk_q <= 1'b1;
        end
        SHIFT: begin
          if (tick) begin
            if (sclk_q) begin
              sclk_q  <= 1'b0;
              shift_q <= shift_q << 1;
              if (bit_cnt == 4'd0) begin
                bits_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 4'd1;
              end
            end else if (!bits_done) begin
              sclk_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SPI_CTRL_READ_EN
  // Read data is captured on the rising edges of bits 7..0 and published with done_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_read_q <= 1'b0;
      rx_q      <= '0;
      rdata_q   <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        is_read_q <= !rw_i;
      end
      if (state == SHIFT && tick && !sclk_q && !bits_done && bit_cnt <= 4'd7) begin
        rx_q <= {rx_q[DATA_W-2:0], cipo_i};
      end
      if (state == HOLD && tick && is_read_q) begin
        rdata_q <= rx_q;
      end
    end
  end
`endif

  assign sclk_o = sclk_q;
  assign copi_o = shift_q[FRAME_W-1];
  assign done_o = done_q;

endmodule

// File: tb/tb_spi_reg_write_ctrl.sv
// Directed bench for spi_reg_write_ctrl: instance 0 uses CLK_DIV=4, instance 1 CLK_DIV=2.
// Read-path steps are included when SPI_CTRL_READ_EN is defined.
module tb_spi_reg_write_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic [6:0] addr  [2];
  logic [7:0] data  [2];
  logic       busy  [2];
  logic       done  [2];
  logic       sclk  [2];
  logic       copi  [2];
  logic       ncs   [2];
`ifdef SPI_CTRL_READ_EN
  logic       rw    [2];
  logic       cipo  [2] = '{1'b0, 1'b0};
  logic [7:0] rdata [2];
  logic [7:0] rd_val[2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_write_ctrl #(.CLK_DIV(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .addr_i(addr[0]), .data_i(data[0]),
`ifdef SPI_CTRL_READ_EN
    .rw_i(rw[0]), .cipo_i(cipo[0]), .rdata_o(rdata[0]),
`endif
    .busy_o(busy[0]), .done_o(done[0]), .sclk_o(sclk[0]), .copi_o(copi[0]), .ncs_o(ncs[0])
  );

  spi_reg_write_ctrl #(.CLK_DIV(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .addr_i(addr[1]), .data_i(data[1]),
`ifdef SPI_CTRL_READ_EN
    .rw_i(rw[1]), .cipo_i(cipo[1]), .rdata_o(rdata[1]),
`endif
    .busy_o(busy[1]), .done_o(done[1]), .sclk_o(sclk[1]), .copi_o(copi[1]), .ncs_o(ncs[1])
  );

  // Bench-side Mode-0 peripheral: samples COPI on SCLK rise, tracks CS run lengths.
  int          rise_cnt  [2];
  int          done_cnt  [2];
  int          viol_cnt  [2];
  int          low_run   [2];
  int          hi_run    [2];
  int          last_low  [2];
  int          last_gap  [2];
  int          frame_fall[2];
  logic [15:0] cap       [2];
  bit          sclk_prev [2];
  bit          ncs_prev  [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ncs[i] === 1'b0) begin
        if (ncs_prev[i]) begin
          last_gap[i]   = hi_run[i];
          low_run[i]    = 0;
          frame_fall[i] = 0;
        end
        low_run[i]++;
      end else begin
        if (!ncs_prev[i]) begin
          last_low[i] = low_run[i];
          hi_run[i]   = 0;
        end
        hi_run[i]++;
      end
      if (sclk[i] === 1'b1 && !sclk_prev[i]) begin
        rise_cnt[i]++;
        cap[i] = {cap[i][14:0], copi[i]};
      end
      if (sclk[i] === 1'b0 && sclk_prev[i]) begin
        frame_fall[i]++;
`ifdef SPI_CTRL_READ_EN
        if (frame_fall[i] >= 8 && frame_fall[i] <= 15) cipo[i] = rd_val[i][15 - frame_fall[i]];
        else cipo[i] = 1'b0;
`endif
      end
      if (sclk[i] === 1'b1 && ncs[i] === 1'b1) viol_cnt[i]++;
      if (done[i] === 1'b1) done_cnt[i]++;
      sclk_prev[i] = (sclk[i] === 1'b1);
      ncs_prev[i]  = (ncs[i] === 1'b1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request at a negedge; returns just after the accept edge.
  task automatic applyStimulus(input int u, input logic [6:0] a, input logic [7:0] d,
                               input logic rw_bit, input logic hold);
    @(negedge clk);
    start[u] = 1'b1;
    addr[u]  = a;
    data[u]  = d;
`ifdef SPI_CTRL_READ_EN
    rw[u]    = rw_bit;
`else
    if (rw_bit !== 1'b1) $display("[TB] note: read request ignored in write-only build");
`endif
    @(posedge clk);
    #1;
    if (!hold) start[u] = 1'b0;
  endtask

  task automatic waitDone(input int u, input int budget, output int edges);
    edges = 0;
    while (edges < budget && done[u] !== 1'b1) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic waitIdle(input int u, input int budget, output int edges);
    edges = 0;
    while (edges < budget && busy[u] !== 1'b0) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  int k;
  int k2;
  int r0;
  int d0;
  int v0;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      addr[i]  = '0;
      data[i]  = '0;
`ifdef SPI_CTRL_READ_EN
      rw[i]     = 1'b1;
      rd_val[i] = 8'h00;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy[0], 1'b0);
    checkOutput("reset_done", done[0], 1'b0);
    checkOutput("reset_sclk", sclk[0], 1'b0);
    checkOutput("reset_copi", copi[0], 1'b0);
    checkOutput("reset_ncs", ncs[0], 1'b1);
`ifdef SPI_CTRL_READ_EN
    checkOutput("reset_rdata", rdata[0], 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single write 0x00/0xA5
    r0 = rise_cnt[0]; d0 = done_cnt[0]; v0 = viol_cnt[0];
    applyStimulus(0, 7'h00, 8'hA5, 1'b1, 1'b0);
    checkOutput("w1_busy_after_accept", busy[0], 1'b1);
    checkOutput("w1_ncs_after_accept", ncs[0], 1'b0);
    checkOutput("w1_copi_bit15", copi[0], 1'b1);
    waitDone(0, 400, k);
    checkOutput("w1_done_latency", k, 136);
    checkOutput("w1_ncs_in_done", ncs[0], 1'b1);
    waitIdle(0, 50, k2);
    checkOutput("w1_busy_fall", k + k2, 140);
    checkOutput("w1_frame", cap[0], 16'h80A5);
    checkOutput("w1_rises", rise_cnt[0] - r0, 16);
    checkOutput("w1_ncs_low", last_low[0], 136);
    checkOutput("w1_done_pulses", done_cnt[0] - d0, 1);
    checkOutput("w1_sclk_while_ncs_hi", viol_cnt[0] - v0, 0);

    // Back-to-back with start held; inputs change right after the first accept
    r0 = rise_cnt[0]; v0 = viol_cnt[0];
    applyStimulus(0, 7'h04, 8'hFF, 1'b1, 1'b1);
    addr[0] = 7'h7F;
    data[0] = 8'h00;
    waitDone(0, 400, k);
    checkOutput("b2b_done1_latency", k, 136);
    waitIdle(0, 50, k2);
    checkOutput("b2b_frame1", cap[0], 16'h84FF);
    @(posedge clk);
    #1;
    checkOutput("b2b_second_accept", busy[0], 1'b1);
    start[0] = 1'b0;
    waitDone(0, 400, k);
    checkOutput("b2b_done2_latency", k, 136);
    waitIdle(0, 50, k2);
    checkOutput("b2b_frame2", cap[0], 16'hFF00);
    checkOutput("b2b_ncs_gap", last_gap[0], 5);
    checkOutput("b2b_rises", rise_cnt[0] - r0, 32);
    checkOutput("b2b_sclk_while_ncs_hi", viol_cnt[0] - v0, 0);

    // Start pulse during busy must be ignored
    d0 = done_cnt[0];
    applyStimulus(0, 7'h11, 8'h22, 1'b1, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    start[0] = 1'b1;
    addr[0]  = 7'h33;
    data[0]  = 8'h44;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    waitDone(0, 400, k);
    checkOutput("busy_start_done_latency", k, 86);
    waitIdle(0, 50, k2);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busy_start_stays_idle", busy[0], 1'b0);
    checkOutput("busy_start_done_pulses", done_cnt[0] - d0, 1);
    checkOutput("busy_start_frame", cap[0], 16'h9122);

    // Reset while bit 6 is on the wire
    r0 = rise_cnt[0]; d0 = done_cnt[0];
    applyStimulus(0, 7'h55, 8'h66, 1'b1, 1'b0);
    k = 0;
    while (k < 400 && (rise_cnt[0] - r0) < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("rst_reached_bit6", (rise_cnt[0] - r0), 10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ncs", ncs[0], 1'b1);
    checkOutput("rst_sclk", sclk[0], 1'b0);
    checkOutput("rst_busy", busy[0], 1'b0);
    checkOutput("rst_done", done[0], 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_no_done_pulse", done_cnt[0] - d0, 0);

    r0 = rise_cnt[0];
    applyStimulus(0, 7'h02, 8'h3C, 1'b1, 1'b0);
    waitDone(0, 400, k);
    checkOutput("post_rst_done_latency", k, 136);
    waitIdle(0, 50, k2);
    checkOutput("post_rst_frame", cap[0], 16'h823C);
    checkOutput("post_rst_rises", rise_cnt[0] - r0, 16);

    // CLK_DIV=2 instance
    r0 = rise_cnt[1];
    applyStimulus(1, 7'h01, 8'h01, 1'b1, 1'b0);
    waitDone(1, 400, k);
    checkOutput("div2_done_latency", k, 68);
    waitIdle(1, 50, k2);
    checkOutput("div2_busy_fall", k + k2, 70);
    checkOutput("div2_frame", cap[1], 16'h8101);
    checkOutput("div2_ncs_low", last_low[1], 68);
    checkOutput("div2_rises", rise_cnt[1] - r0, 16);
    checkOutput("div2_sclk_while_ncs_hi", viol_cnt[1], 0);

`ifdef SPI_CTRL_READ_EN
    rd_val[0] = 8'h5A;
    applyStimulus(0, 7'h03, 8'h00, 1'b0, 1'b0);
    waitDone(0, 400, k);
    checkOutput("rd_done_latency", k, 136);
    checkOutput("rd_rdata_in_done", rdata[0], 8'h5A);
    waitIdle(0, 50, k2);
    checkOutput("rd_frame_hi", cap[0][15:8], 8'h03);
    rd_val[0] = 8'hC3;
    applyStimulus(0, 7'h10, 8'h99, 1'b1, 1'b0);
    waitDone(0, 400, k);
    checkOutput("wr_after_rd_rdata", rdata[0], 8'h5A);
    waitIdle(0, 50, k2);
    checkOutput("wr_after_rd_frame", cap[0], 16'h9099);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
